// File: rtl/key_filter_if.sv
// Key filter signal bundle: slow-clock and raw key in, debounced level and event pulses out.
interface key_filter_if;
  logic clk_slow;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  modport master (
    output clk_slow,
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  clk_slow,
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_filter.sv
// Debounces a mechanical key on ticks derived from a slow divided clock and emits
// press / release / long-press pulses plus a debounced level, all in the clk_100m domain.
module key_filter #(
  parameter int unsigned STABLE_TICKS = 2,
  parameter int unsigned LONG_TICKS   = 20,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic         clk_100m,
  input  logic         rst,
  key_filter_if.slave  kf
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, DOWN, LONG} state_e;

  localparam logic [7:0]  STABLE_LIM = 8'(STABLE_TICKS);
  localparam logic [15:0] LONG_LIM   = 16'(LONG_TICKS);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic key_act;
  logic key_s1_q, key_s2_q;
  logic slow_s1_q, slow_s2_q, slow_s3_q;
  logic tick_q;
  logic key_s;

  // Polarity is folded in before the synchronizer so a cleared flop means "released".
  assign key_act = ACTIVE_LOW ? ~kf.key_in : kf.key_in;
  assign key_s   = key_s2_q;

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      key_s1_q  <= 1'b0;
      key_s2_q  <= 1'b0;
      slow_s1_q <= 1'b0;
      slow_s2_q <= 1'b0;
      slow_s3_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      key_s1_q  <= key_act;
      key_s2_q  <= key_s1_q;
      slow_s1_q <= kf.clk_slow;
      slow_s2_q <= slow_s1_q;
      slow_s3_q <= slow_s2_q;
      tick_q    <= slow_s2_q & ~slow_s3_q;
    end
  end

  state_e      state_q, state_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [7:0]  rel_cnt_q, rel_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        acc_press, acc_rel, hit_long;

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_q    <= IDLE;
      stab_cnt_q <= 8'd0;
      rel_cnt_q  <= 8'd0;
      hold_cnt_q <= 16'd0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    hold_cnt_d = hold_cnt_q;
    acc_press  = 1'b0;
    acc_rel    = 1'b0;
    hit_long   = 1'b0;
    if (tick_q) begin
      case (state_q)
        IDLE: begin
          if (key_s) begin
            if (STABLE_LIM <= 8'd1) begin
              acc_press = 1'b1;
            end else begin
              stab_cnt_d = 8'd1;
              state_d    = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (key_s) begin
            if (sat_inc8(stab_cnt_q) >= STABLE_LIM) acc_press = 1'b1;
            else stab_cnt_d = sat_inc8(stab_cnt_q);
          end else begin
            stab_cnt_d = 8'd0;
            state_d    = IDLE;
          end
        end
        DOWN, LONG: begin
          if (!key_s) begin
            if (sat_inc8(rel_cnt_q) >= STABLE_LIM) acc_rel = 1'b1;
            else rel_cnt_d = sat_inc8(rel_cnt_q);
          end else begin
            rel_cnt_d = 8'd0;
          end
          // Release on the same tick as the long threshold suppresses the long pulse.
          if (state_q == DOWN) begin
            hold_cnt_d = sat_inc16(hold_cnt_q);
            if (sat_inc16(hold_cnt_q) == LONG_LIM && !acc_rel) begin
              hit_long = 1'b1;
              state_d  = LONG;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (acc_press) begin
        state_d    = DOWN;
        stab_cnt_d = 8'd0;
        hold_cnt_d = 16'd0;
        rel_cnt_d  = 8'd0;
      end
      if (acc_rel) begin
        state_d    = IDLE;
        stab_cnt_d = 8'd0;
        hold_cnt_d = 16'd0;
        rel_cnt_d  = 8'd0;
      end
    end
  end

  always_comb begin
    press_d   = acc_press;
    release_d = acc_rel;
    long_d    = hit_long;
    level_d   = level_q;
    if (acc_press) level_d = 1'b1;
    if (acc_rel)   level_d = 1'b0;
  end

  assign kf.key_level   = level_q;
  assign kf.key_press   = press_q;
  assign kf.key_release = release_q;
  assign kf.key_long    = long_q;

endmodule

// File: tb/tb_key_filter.sv
// Scenario bench for key_filter: expected pulses are queued per slow tick and matched as the DUT emits them.
module tb_key_filter;

  logic clk_100m = 1'b0;
  logic rst      = 1'b1;

  key_filter_if kif ();

  key_filter #(
    .STABLE_TICKS (2),
    .LONG_TICKS   (4),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk_100m (clk_100m),
    .rst      (rst),
    .kf       (kif)
  );

  always #5 clk_100m = ~clk_100m;

  localparam int EV_PRESS = 1;
  localparam int EV_REL   = 2;
  localparam int EV_LONG  = 3;

  typedef struct packed {
    int ev;
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  bit   slow_en = 1'b0;
  int   div     = 0;

  // clk_slow toggles every 8 clk_100m cycles while enabled: one rising edge per 16 clocks.
  initial begin
    kif.clk_slow = 1'b0;
    forever begin
      @(negedge clk_100m);
      if (slow_en) begin
        div++;
        if (div == 8) begin
          div = 0;
          kif.clk_slow = ~kif.clk_slow;
        end
      end
    end
  end

  int   mon_n;
  int   mon_got;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk_100m);
      cyc++;
      mon_n   = int'(kif.key_press) + int'(kif.key_release) + int'(kif.key_long);
      mon_got = kif.key_press ? EV_PRESS : kif.key_release ? EV_REL : kif.key_long ? EV_LONG : 0;
      if (mon_n != 0) begin
        n_cmp++;
        if (mon_n > 1) begin
          n_bad++;
          $display("FAIL pulse_exclusive: %0d pulses high at cycle %0d, required 1", mon_n, cyc);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: event %0d at cycle %0d, required none", mon_got, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_got !== mon_e.ev) begin
            n_bad++;
            $display("FAIL event_kind: got event %0d at cycle %0d, required %0d", mon_got, cyc, mon_e.ev);
          end
          n_cmp++;
          if (cyc < mon_e.lo || cyc > mon_e.hi) begin
            n_bad++;
            $display("FAIL event_time: event %0d at cycle %0d, required %0d..%0d",
                     mon_got, cyc, mon_e.lo, mon_e.hi);
          end
        end
      end
    end
  end

  // One slow tick: drive the raw key, expect an optional pulse from the coming tick, check the level after it.
  task automatic step(input logic raw, input int ev, input logic exp_lvl, input string name);
    exp_t e;
    kif.key_in = raw;
    if (ev != 0) begin
      e.ev = ev;
      e.lo = cyc + 1;
      e.hi = cyc + 16;
      sb.push_back(e);
    end
    @(negedge kif.clk_slow);
    n_cmp++;
    if (kif.key_level !== exp_lvl) begin
      n_bad++;
      $display("FAIL %s: key_level=%0b, required %0b", name, kif.key_level, exp_lvl);
    end
  endtask

  task automatic test_reset();
    kif.key_in = 1'b0;
    rst        = 1'b1;
    slow_en    = 1'b1;
    repeat (40) @(negedge clk_100m);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (kif.key_level !== 1'b0) begin
        n_bad++; $display("FAIL reset_level: %0b, required 0", kif.key_level);
      end
      n_cmp++;
      if (kif.key_press !== 1'b0) begin
        n_bad++; $display("FAIL reset_press: %0b, required 0", kif.key_press);
      end
      n_cmp++;
      if (kif.key_release !== 1'b0) begin
        n_bad++; $display("FAIL reset_release: %0b, required 0", kif.key_release);
      end
      n_cmp++;
      if (kif.key_long !== 1'b0) begin
        n_bad++; $display("FAIL reset_long: %0b, required 0", kif.key_long);
      end
      repeat (7) @(negedge clk_100m);
    end
    kif.key_in = 1'b1;
    repeat (10) @(negedge clk_100m);
    rst = 1'b0;
    @(negedge kif.clk_slow);
    step(1'b1, 0, 1'b0, "reset_idle_0");
    step(1'b1, 0, 1'b0, "reset_idle_1");
  endtask

  task automatic test_clean_press();
    step(1'b0, 0,        1'b0, "clean_t1");
    step(1'b0, EV_PRESS, 1'b1, "clean_t2");
    step(1'b0, 0,        1'b1, "clean_t3");
    step(1'b0, 0,        1'b1, "clean_t4");
    step(1'b0, 0,        1'b1, "clean_t5");
    step(1'b0, EV_LONG,  1'b1, "clean_t6");
    step(1'b1, 0,        1'b1, "clean_r1");
    step(1'b1, EV_REL,   1'b0, "clean_r2");
    step(1'b1, 0,        1'b0, "clean_idle");
  endtask

  task automatic test_bounce();
    step(1'b0, 0, 1'b0, "bounce_t1");
    step(1'b1, 0, 1'b0, "bounce_t2");
    step(1'b0, 0, 1'b0, "bounce_t3");
    step(1'b1, 0, 1'b0, "bounce_t4");
    step(1'b1, 0, 1'b0, "bounce_t5");
  endtask

  task automatic test_short_press();
    step(1'b0, 0,        1'b0, "short_t1");
    step(1'b0, EV_PRESS, 1'b1, "short_t2");
    step(1'b0, 0,        1'b1, "short_t3");
    step(1'b1, 0,        1'b1, "short_r1");
    step(1'b1, EV_REL,   1'b0, "short_r2");
    step(1'b1, 0,        1'b0, "short_idle");
  endtask

  // Last tick reaches both the long threshold and release acceptance: only the release may appear.
  task automatic test_release_bounce();
    step(1'b0, 0,        1'b0, "rbounce_t1");
    step(1'b0, EV_PRESS, 1'b1, "rbounce_t2");
    step(1'b1, 0,        1'b1, "rbounce_t3");
    step(1'b0, 0,        1'b1, "rbounce_t4");
    step(1'b1, 0,        1'b1, "rbounce_t5");
    step(1'b1, EV_REL,   1'b0, "rbounce_t6");
    step(1'b1, 0,        1'b0, "rbounce_idle");
  endtask

  task automatic test_reset_mid_hold();
    step(1'b0, 0,        1'b0, "rmid_t1");
    step(1'b0, EV_PRESS, 1'b1, "rmid_t2");
    step(1'b0, 0,        1'b1, "rmid_t3");
    step(1'b0, 0,        1'b1, "rmid_t4");
    step(1'b0, 0,        1'b1, "rmid_t5");
    step(1'b0, EV_LONG,  1'b1, "rmid_t6");
    @(negedge clk_100m);
    rst = 1'b1;
    @(negedge clk_100m);
    rst = 1'b0;
    n_cmp++;
    if (kif.key_level !== 1'b0) begin
      n_bad++; $display("FAIL rmid_level: %0b, required 0", kif.key_level);
    end
    n_cmp++;
    if ({kif.key_press, kif.key_release, kif.key_long} !== 3'b000) begin
      n_bad++;
      $display("FAIL rmid_pulses: %b, required 000", {kif.key_press, kif.key_release, kif.key_long});
    end
    step(1'b0, 0,        1'b0, "rmid_p1");
    step(1'b0, EV_PRESS, 1'b1, "rmid_p2");
    step(1'b1, 0,        1'b1, "rmid_r1");
    step(1'b1, EV_REL,   1'b0, "rmid_r2");
  endtask

  task automatic test_static_slow();
    step(1'b0, 0,        1'b0, "static_t1");
    step(1'b0, EV_PRESS, 1'b1, "static_t2");
    slow_en = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_100m);
      kif.key_in = 1'(($urandom_range(0, 1)));
    end
    kif.key_in = 1'b0;
    repeat (5) @(negedge clk_100m);
    n_cmp++;
    if (kif.key_level !== 1'b1) begin
      n_bad++; $display("FAIL static_level: %0b, required 1", kif.key_level);
    end
    slow_en = 1'b1;
    step(1'b0, 0,      1'b1, "static_t3");
    step(1'b1, 0,      1'b1, "static_r1");
    step(1'b1, EV_REL, 1'b0, "static_r2");
  endtask

  initial begin
    kif.key_in = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_press();
    test_release_bounce();
    test_reset_mid_hold();
    test_static_slow();
    repeat (20) @(negedge clk_100m);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: %0d expected pulses never seen, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
